// File: rtl/act_pkg.sv
// act_pkg
//   Shared definitions for the activation LUT loader and the LUT reader.
//   - loader_state_t : loader FSM states
//   - lut_depth()    : number of LUT entries for a given address width
package act_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

  function automatic int unsigned lut_depth(input int unsigned mem_width);
    return 32'd1 << mem_width;
  endfunction

endpackage

// File: rtl/act_lut_loader_if.sv
// act_lut_loader_if
//   Bundles the loader's streaming input and its LUT write port.
//   Ports (signals):
//     s_valid / s_data / s_ready      : input beat handshake
//     lut_we / lut_waddr / lut_wdata  : LUT write port
//   Modports:
//     master : beat source, observes the write port
//     slave  : the loader (accepts beats, drives the write port)
interface act_lut_loader_if #(
  parameter int MEM_WIDTH     = 5,
  parameter int IP_DATA_WIDTH = 8
);

  logic                     s_valid;
  logic [IP_DATA_WIDTH-1:0] s_data;
  logic                     s_ready;
  logic                     lut_we;
  logic [MEM_WIDTH-1:0]     lut_waddr;
  logic [IP_DATA_WIDTH-1:0] lut_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, lut_we, lut_waddr, lut_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, lut_we, lut_waddr, lut_wdata
  );

endinterface

// File: rtl/act_lut_loader.sv
// act_lut_loader
//   Streams 2**MEM_WIDTH entries into the activation LUT after a start pulse.
//   Beat k is written to address k through a registered write port, a
//   running checksum of accepted data is kept, and done is raised (sticky
//   until the next start or reset) once the table is full.
//   Ports:
//     clk      : clock, all logic on posedge
//     rst      : synchronous active-high reset
//     start    : single-cycle load request (ignored while loading)
//     bus      : slave side of act_lut_loader_if (beats in, LUT writes out)
//     busy     : load in progress
//     done     : table fully written
//     checksum : sum of accepted beats, modulo 2**IP_DATA_WIDTH
module act_lut_loader
  import act_pkg::*;
#(
  parameter int MEM_WIDTH     = 5,
  parameter int IP_DATA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  act_lut_loader_if.slave          bus,
  output logic                     busy,
  output logic                     done,
  output logic [IP_DATA_WIDTH-1:0] checksum
);

  localparam int unsigned          DEPTH     = lut_depth(MEM_WIDTH);
  localparam logic [MEM_WIDTH-1:0] LAST_ADDR = MEM_WIDTH'(DEPTH - 1);

  loader_state_t            state_q, state_d;
  logic [MEM_WIDTH-1:0]     cnt_q, cnt_d;
  logic [IP_DATA_WIDTH-1:0] sum_q, sum_d;
  logic                     we_q, we_d;
  logic [MEM_WIDTH-1:0]     waddr_q, waddr_d;
  logic [IP_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                     accept;

  assign accept = (state_q == LOAD) && bus.s_valid;

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      LOAD: begin
        // start is deliberately not looked at here: a reload request in
        // the middle of a load is dropped.
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = cnt_q;
          wdata_d = bus.s_data;
          cnt_d   = cnt_q + 1'b1;  // wraps to 0 after the last entry
          sum_d   = sum_q + bus.s_data;
          if (cnt_q == LAST_ADDR) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  // The write-port registers are reset too because they are visible outputs;
  // the LUT storage itself lives outside and keeps its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.s_ready   = (state_q == LOAD);
  assign bus.lut_we    = we_q;
  assign bus.lut_waddr = waddr_q;
  assign bus.lut_wdata = wdata_q;
  assign busy          = (state_q == LOAD);
  assign done          = (state_q == DONE);
  assign checksum      = sum_q;

endmodule
